// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl
//
// Sequencer for exhaustive equivalence checking of two combinational forms of one
// boolean function: a complex form and a simplified form. It steps through every
// input vector in ascending order and holds each vector for SETTLE idle cycles.
// It then compares the two unit outputs, counts mismatching vectors, and records
// the first failing vector index.
//
// Parameters
//   N_IN    number of function inputs; the sweep covers 2**N_IN vectors
//   SETTLE  idle cycles each vector is held before it is sampled (0..15)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous reset, active-low
//   start       begin a sweep (only honoured in IDLE/DONE)
//   abort       cancel a running sweep (only honoured in RUN)
//   com_in      output of the complex-form unit
//   sim_in      output of the simplified-form unit
//   vec         vector applied to both units (MSB = x, then y, w, z for N_IN=4)
//   busy        sweep in progress
//   done        sweep finished; held until the next start, abort or reset
//   pass        done with no mismatches
//   mism_cnt    number of mismatching vectors (0..2**N_IN, never wraps)
//   fail_valid  first_fail holds a valid index
//   first_fail  index of the first mismatching vector
//
// Optional feature (macro EQUIV_STOP_ON_FAIL_EN)
//   When defined, the sweep ends on the first mismatching sample. vec then holds
//   the failing vector. When undefined, all 2**N_IN vectors are always checked.

module equiv_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            com_in,
  input  logic            sim_in,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mism_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] VEC_MAX  = '1;
  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;

  assign mismatch = com_in ^ sim_in;

  // Status flags are pure decodes of the registered state and count.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (mism_cnt == '0);

  // Sweep sequencer. A vector is held while the settle counter runs down.
  // The cycle on which the counter reads zero is the sample cycle. On that
  // cycle the comparison is recorded and the sweep either advances or ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      mism_cnt   <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            vec        <= '0;
            mism_cnt   <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            settle_cnt <= SETTLE_V;
          end
        end

        RUN: begin
          if (abort) begin
            // Counters keep their values so a monitor can still read the partial result.
            state <= IDLE;
            vec   <= '0;
          end else if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            if (mismatch) begin
              mism_cnt <= mism_cnt + {{N_IN{1'b0}}, 1'b1};
              if (!fail_valid) begin
                first_fail <= vec;
                fail_valid <= 1'b1;
              end
            end
`ifdef EQUIV_STOP_ON_FAIL_EN
            if (mismatch || (vec == VEC_MAX)) begin
              state <= DONE;
            end else begin
              vec        <= vec + {{(N_IN-1){1'b0}}, 1'b1};
              settle_cnt <= SETTLE_V;
            end
`else
            if (vec == VEC_MAX) begin
              state <= DONE;
            end else begin
              vec        <= vec + {{(N_IN-1){1'b0}}, 1'b1};
              settle_cnt <= SETTLE_V;
            end
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// tb_equiv_sweep_ctrl
//
// Directed bench for equiv_sweep_ctrl with the default parameters (N_IN=4, SETTLE=1).
// The two "units" are modelled by the bench. com_in is the parity of vec. sim_in
// is the same parity XORed with a per-vector mismatch mask, so any chosen set of
// vectors can be made to disagree.
//
// A sweep-level model tracks the position within a sweep as the number of elapsed
// RUN cycles. It derives the current vector and the sample cycles from that count
// and the cycles-per-vector. The model is compared against the DUT on every
// falling edge. Literal expectations after each scenario pin the model itself.

module tb_equiv_sweep_ctrl;

  localparam int N_IN   = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 1 << N_IN;
  localparam int CPV    = SETTLE + 1;
`ifdef EQUIV_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            com_in;
  logic            sim_in;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mism_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail;

  logic [NVEC-1:0] mask = '0;

  int errors = 0;
  int checks = 0;

  equiv_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .com_in     (com_in),
    .sim_in     (sim_in),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .mism_cnt   (mism_cnt),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  assign com_in = ^vec;
  assign sim_in = (^vec) ^ mask[vec];

  // Sweep model: phase 0 idle, 1 run, 2 done.
  int m_ph    = 0;
  int m_cyc   = 0;
  int m_held  = 0;
  int m_cnt   = 0;
  bit m_fv    = 1'b0;
  int m_ff    = 0;
  bit m_valid = 1'b0;

  function automatic int exp_vec();
    return (m_ph == 1) ? (m_cyc / CPV) : m_held;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge, using the inputs held since the previous edge.
  always @(posedge clk) begin
    int v;
    if (!rst_n) begin
      m_ph = 0; m_cyc = 0; m_held = 0; m_cnt = 0; m_fv = 1'b0; m_ff = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_ph)
        0, 2: if (start) begin
          m_ph = 1; m_cyc = 0; m_cnt = 0; m_fv = 1'b0; m_ff = 0;
        end
        1: if (abort) begin
          m_ph = 0; m_held = 0;
        end else begin
          v = m_cyc / CPV;
          if ((m_cyc % CPV) == CPV - 1) begin
            if (mask[v]) begin
              m_cnt++;
              if (!m_fv) begin m_fv = 1'b1; m_ff = v; end
            end
            if (v == NVEC - 1 || (STOP && mask[v])) begin
              m_ph = 2; m_held = v;
            end else begin
              m_cyc++;
            end
          end else begin
            m_cyc++;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model once a reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("busy",       int'(busy),       int'(m_ph == 1));
      checkOutput("done",       int'(done),       int'(m_ph == 2));
      checkOutput("pass",       int'(pass),       int'(m_ph == 2 && m_cnt == 0));
      checkOutput("vec",        int'(vec),        exp_vec());
      checkOutput("mism_cnt",   int'(mism_cnt),   m_cnt);
      checkOutput("fail_valid", int'(fail_valid), int'(m_fv));
      checkOutput("first_fail", int'(first_fail), m_ff);
    end
  end

  // Drive one edge's worth of inputs, changed just after the active edge.
  task automatic applyStimulus(input logic s, input logic a, input logic r);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
    rst_n = r;
  endtask

  task automatic runSweep(output int busy_cycles);
    busy_cycles = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cycles++;
    end
    checkOutput("done_reached", int'(done), 1);
    #1;
  endtask

  task automatic waitVec(input int v);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(vec) == v && busy) begin seen = 1'b1; break; end
    end
    checkOutput("vec_reached", int'(seen), 1);
  endtask

  initial begin
    int bc;
    int exp_m;

    $display("[TB] equiv_sweep_ctrl bench, stop-on-fail=%0d", STOP);

    // 1. Reset held for two cycles.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_vec",  int'(vec), 0);
    checkOutput("rst_mism", int'(mism_cnt), 0);
    checkOutput("rst_fv",   int'(fail_valid), 0);
    checkOutput("rst_pass", int'(pass), 0);

    // Abort outside RUN is ignored.
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_abort_busy", int'(busy), 0);

    // 2. Equivalent forms: full clean sweep.
    mask = '0;
    runSweep(bc);
    checkOutput("clean_busy_cycles", bc, NVEC * CPV);
    checkOutput("clean_pass", int'(pass), 1);
    checkOutput("clean_mism", int'(mism_cnt), 0);
    checkOutput("clean_fv",   int'(fail_valid), 0);
    checkOutput("clean_vec",  int'(vec), NVEC - 1);

    // 3. Mismatches at vectors 5 and 12.
    mask = 16'h1020;
    runSweep(bc);
    checkOutput("m2_pass", int'(pass), 0);
    checkOutput("m2_first", int'(first_fail), 5);
    checkOutput("m2_mism", int'(mism_cnt), STOP ? 1 : 2);
    checkOutput("m2_vec",  int'(vec), STOP ? 5 : 15);
    checkOutput("m2_busy_cycles", bc, STOP ? 6 * CPV : NVEC * CPV);

    // 4. Every vector mismatches; the count must not wrap.
    mask = '1;
    runSweep(bc);
    checkOutput("all_mism",  int'(mism_cnt), STOP ? 1 : 16);
    checkOutput("all_first", int'(first_fail), 0);
    checkOutput("all_fv",    int'(fail_valid), 1);

    // 5. A start pulse during RUN is ignored; a start in DONE clears and restarts.
    mask = '0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("restart_mism", int'(mism_cnt), 0);
    checkOutput("restart_fv",   int'(fail_valid), 0);
    waitVec(3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_start_busy", int'(busy), 1);
    checkOutput("run_start_vec",  int'(vec), 4);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checkOutput("restart_done", int'(done), 1);
    checkOutput("restart_pass", int'(pass), 1);

    // 6. Abort at vector 7 (with start asserted too: abort wins in RUN).
    mask  = STOP ? 16'h0000 : 16'h0004;
    exp_m = STOP ? 0 : 1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitVec(7);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_vec",  int'(vec), 0);
    checkOutput("abort_mism", int'(mism_cnt), exp_m);

    // Start and abort together in IDLE: start wins. Then reset at vector 9.
    mask = '0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_both_busy", int'(busy), 1);
    waitVec(9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_vec",  int'(vec), 0);
    checkOutput("midrst_mism", int'(mism_cnt), 0);

    // Short sweep after the mid-sweep reset to show normal operation resumes.
    mask = 16'h8000;
    runSweep(bc);
    checkOutput("final_first", int'(first_fail), 15);
    checkOutput("final_mism",  int'(mism_cnt), 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
